// File: rtl/brick_wall.sv
// Brick-wall collision engine: scans one brick per clock against the latched
// ball position, retires at most one brick per frame, and keeps score.
//   IDLE     | waiting for a frame strobe
//   SCAN     | testing brick idx against the latched ball
//   HIT_WAIT | hit reported, holding until the ball acknowledges
module brick_wall #(
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int B_WIDTH  = 30,
  parameter int B_HEIGHT = 5,
  parameter int X0       = 40,
  parameter int Y0       = 20,
  parameter int PITCH_X  = 70,
  parameter int PITCH_Y  = 15,
  parameter int S_SIZE   = 5,
  parameter int SCORE_W  = 9,
  parameter int PTS      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ani_stb,
  input  logic                 i_animate,
  input  logic                 i_mode,
  input  logic                 i_ack,
  input  logic [11:0]          s_x,
  input  logic [11:0]          s_y,
  output logic [ROWS*COLS-1:0] o_alive,
  output logic [SCORE_W-1:0]   o_score,
  output logic [1:0]           o_hit,
  output logic                 o_hit_valid,
  output logic                 o_cleared,
  output logic                 o_busy
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic signed [12:0] HW   = 13'(B_WIDTH + S_SIZE);
  localparam logic signed [12:0] HH   = 13'(B_HEIGHT + S_SIZE);
  localparam logic signed [12:0] TWO  = 13'sd2;
  localparam logic signed [12:0] CX0  = 13'(X0);
  localparam logic signed [12:0] CY0  = 13'(Y0);
  localparam logic signed [12:0] PX   = 13'(PITCH_X);
  localparam logic signed [12:0] PY   = 13'(PITCH_Y);
  localparam logic [SCORE_W:0]   MAXS = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0]   PTSW = (SCORE_W+1)'(PTS);

  typedef enum logic [1:0] {IDLE, SCAN, HIT_WAIT} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      col;
  logic signed [12:0] bx, by, cx, cy;
  logic [1:0]         hit_code;
  logic               xin, yin;
  logic [SCORE_W:0]   score_sum;

  // Brick centre is tracked incrementally with the column counter, so no
  // multiplier is needed to locate brick idx.
  always_comb begin
    hit_code = 2'b00;
    xin = (bx >= cx - HW) && (bx <= cx + HW);
    yin = (by >= cy - HH) && (by <= cy + HH);
    if ((bx == cx + HW || bx == cx - HW) && (by == cy + HH || by == cy - HH))
      hit_code = 2'b11;
    else if (by >= cy + HH - TWO && by <= cy + HH && xin)
      hit_code = 2'b01;
    else if (by >= cy - HH && by <= cy - HH + TWO && xin)
      hit_code = 2'b01;
    else if (bx >= cx + HW - TWO && bx <= cx + HW && yin)
      hit_code = 2'b10;
    else if (bx >= cx - HW && bx <= cx - HW + TWO && yin)
      hit_code = 2'b10;
    if (!o_alive[idx])
      hit_code = 2'b00;
  end

  assign score_sum = {1'b0, o_score} + PTSW;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      idx         <= '0;
      col         <= '0;
      bx          <= '0;
      by          <= '0;
      cx          <= CX0;
      cy          <= CY0;
      o_alive     <= '1;
      o_score     <= '0;
      o_hit       <= 2'b00;
      o_hit_valid <= 1'b0;
      o_cleared   <= 1'b0;
      o_busy      <= 1'b0;
    end else if (!i_mode) begin
      state       <= IDLE;
      idx         <= '0;
      o_alive     <= '1;
      o_score     <= '0;
      o_hit       <= 2'b00;
      o_hit_valid <= 1'b0;
      o_cleared   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_cleared <= (o_alive == '0);
      case (state)
        IDLE: begin
          if (i_ani_stb && i_animate) begin
            bx     <= $signed({1'b0, s_x});
            by     <= $signed({1'b0, s_y});
            idx    <= '0;
            col    <= '0;
            cx     <= CX0;
            cy     <= CY0;
            o_busy <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (hit_code != 2'b00) begin
            o_alive[idx] <= 1'b0;
            o_score      <= (score_sum > MAXS) ? '1 : score_sum[SCORE_W-1:0];
            o_hit        <= hit_code;
            o_hit_valid  <= 1'b1;
            state        <= HIT_WAIT;
          end else if (idx == IW'(N - 1)) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
            if (col == CW'(COLS - 1)) begin
              col <= '0;
              cx  <= CX0;
              cy  <= cy + PY;
            end else begin
              col <= col + 1'b1;
              cx  <= cx + PX;
            end
          end
        end
        HIT_WAIT: begin
          if (i_ack) begin
            o_hit       <= 2'b00;
            o_hit_valid <= 1'b0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_wall.sv
// Directed bench for brick_wall: stimulus queues expected hits, a negedge
// monitor checks each reported hit against the queue.
module tb_brick_wall;
  localparam int N = 32;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ani_stb, i_animate, i_mode, i_ack;
  logic [11:0] s_x, s_y;
  logic [N-1:0] o_alive;
  logic [8:0]  o_score;
  logic [1:0]  o_hit;
  logic        o_hit_valid, o_cleared, o_busy;

  brick_wall dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_mode(i_mode), .i_ack(i_ack), .s_x(s_x), .s_y(s_y),
    .o_alive(o_alive), .o_score(o_score), .o_hit(o_hit),
    .o_hit_valid(o_hit_valid), .o_cleared(o_cleared), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]   hit;
    logic [8:0]   score;
    logic [N-1:0] alive;
    longint       due;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  longint       cyc = 0;
  logic         prev_v = 1'b0;
  logic [N-1:0] model_alive = '1;
  int           model_score = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_hit_valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_hit actual=%0h expected=none", o_hit);
      end else begin
        mon_e = q.pop_front();
        chk("hit_code", 64'(o_hit), 64'(mon_e.hit));
        chk("hit_score", 64'(o_score), 64'(mon_e.score));
        chk("hit_alive", 64'(o_alive), 64'(mon_e.alive));
        chk("hit_busy", 64'(o_busy), 64'd1);
        chk("hit_latency_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
    prev_v = o_hit_valid;
  end

  task automatic mode_pulse();
    @(negedge i_clk) i_mode = 1'b0;
    @(negedge i_clk) i_mode = 1'b1;
    model_alive = '1;
    model_score = 0;
  endtask

  task automatic do_hit(int x, int y, logic [1:0] h, int idx);
    exp_t e;
    bit   got;
    @(negedge i_clk);
    model_alive[idx] = 1'b0;
    model_score++;
    e.hit = h; e.score = 9'(model_score); e.alive = model_alive; e.due = cyc + 2 + idx;
    q.push_back(e);
    s_x = 12'(x); s_y = 12'(y); i_ani_stb = 1'b1;
    @(negedge i_clk) i_ani_stb = 1'b0;
    got = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      if (o_hit_valid) begin got = 1'b1; break; end
      @(negedge i_clk);
    end
    chk("hit_seen", 64'(got), 64'd1);
    if (!got) begin q.delete(); return; end
    @(negedge i_clk);
    chk("hit_hold", 64'(o_hit), 64'(h));
    i_ack = 1'b1;
    @(negedge i_clk) i_ack = 1'b0;
    chk("ack_hit_clear", {61'd0, o_hit, o_hit_valid}, 64'd0);
    chk("ack_busy", 64'(o_busy), 64'd0);
  endtask

  task automatic do_miss(int x, int y);
    int cnt = 0;
    @(negedge i_clk);
    s_x = 12'(x); s_y = 12'(y); i_ani_stb = 1'b1;
    @(negedge i_clk) i_ani_stb = 1'b0;
    for (int k = 0; k < N + 6; k++) begin
      if (!o_busy) break;
      cnt++;
      if (k == 3) i_ani_stb = 1'b1;
      if (k == 4) i_ani_stb = 1'b0;
      @(negedge i_clk);
    end
    i_ani_stb = 1'b0;
    chk("miss_busy_cycles", 64'(cnt), 64'(N));
    repeat (3) @(negedge i_clk);
    chk("miss_stray_strobe_ignored", 64'(o_busy), 64'd0);
    chk("miss_no_hit", {61'd0, o_hit, o_hit_valid}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b1; i_mode = 1'b1; i_ack = 1'b0;
    s_x = '0; s_y = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_alive", 64'(o_alive), {32'd0, 32'hFFFF_FFFF});
    chk("rst_score", 64'(o_score), 64'd0);
    chk("rst_hit", {61'd0, o_hit, o_hit_valid}, 64'd0);
    chk("rst_cleared", 64'(o_cleared), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);

    do_hit(40, 30, 2'b01, 0);
    mode_pulse();
    chk("mode_restore_alive", 64'(o_alive), {32'd0, 32'hFFFF_FFFF});
    do_hit(75, 30, 2'b11, 0);
    mode_pulse();
    do_hit(75, 20, 2'b10, 0);
    do_hit(75, 20, 2'b10, 1);
    chk("two_hits_score", 64'(o_score), 64'd2);
    do_miss(500, 400);

    mode_pulse();
    for (int i = 0; i < N - 1; i++)
      do_hit(40 + (i % 8) * 70, 20 + (i / 8) * 15 + 10, 2'b01, i);
    chk("not_yet_cleared", 64'(o_cleared), 64'd0);
    do_hit(40 + 7 * 70, 20 + 3 * 15 + 10, 2'b01, N - 1);
    chk("all_cleared", 64'(o_cleared), 64'd1);
    chk("all_score", 64'(o_score), 64'd32);
    chk("all_alive_zero", 64'(o_alive), 64'd0);
    do_miss(40, 30);
    mode_pulse();
    chk("restore_alive", 64'(o_alive), {32'd0, 32'hFFFF_FFFF});
    chk("restore_score", 64'(o_score), 64'd0);
    chk("restore_cleared", 64'(o_cleared), 64'd0);

    @(negedge i_clk);
    s_x = 12'd530; s_y = 12'd75; i_ani_stb = 1'b1;
    @(negedge i_clk) i_ani_stb = 1'b0;
    repeat (4) @(negedge i_clk);
    i_mode = 1'b0;
    @(negedge i_clk) i_mode = 1'b1;
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_score", 64'(o_score), 64'd0);
    repeat (N + 2) @(negedge i_clk);
    chk("abort_no_hit", 64'(o_hit_valid), 64'd0);

    do_hit(40, 30, 2'b01, 0);
    @(negedge i_clk);
    s_x = 12'd500; s_y = 12'd400; i_ani_stb = 1'b1;
    @(negedge i_clk) i_ani_stb = 1'b0;
    repeat (3) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_scan_busy", 64'(o_busy), 64'd0);
    chk("arst_scan_score", 64'(o_score), 64'd0);
    chk("arst_scan_alive", 64'(o_alive), {32'd0, 32'hFFFF_FFFF});
    @(negedge i_clk) i_rst = 1'b0;
    model_alive = '1; model_score = 0;

    @(negedge i_clk);
    e.hit = 2'b01; e.score = 9'd1; e.alive = ~32'd1; e.due = cyc + 2;
    q.push_back(e);
    s_x = 12'd40; s_y = 12'd30; i_ani_stb = 1'b1;
    @(negedge i_clk) i_ani_stb = 1'b0;
    @(negedge i_clk);
    chk("hw_valid_before_rst", 64'(o_hit_valid), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_hw_hit", {61'd0, o_hit, o_hit_valid}, 64'd0);
    chk("arst_hw_busy", 64'(o_busy), 64'd0);
    chk("arst_hw_alive", 64'(o_alive), {32'd0, 32'hFFFF_FFFF});
    @(negedge i_clk) i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
